// File: rtl/spi_wo_feeder.sv
// spi_wo_feeder: byte queue and issue sequencer in front of the write-only
// SPI master. Bytes tagged with a D/C bit are pushed into a circular FIFO
// and issued one at a time through the master's start/busy handshake. The
// D/C pin only changes as a byte is popped, while the link is idle.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   wr_i, data_i, dc_i      push {dc_i, data_i}
//   flush_i                 drop all queued entries, clear overflow_o
//   full_o, empty_o         FIFO status
//   level_o                 entries queued (0..2^DEPTH_LOG2)
//   overflow_o              sticky: a write was dropped while full
//   idle_o                  nothing queued, nothing in flight, SPI not busy
//   spi_data_o              byte to the SPI master data input
//   spi_start_o             one-cycle start pulse to the SPI master
//   spi_busy_i              SPI master busy (high during spi_start_o)
//   dc_o                    D/C pin to the peripheral
module spi_wo_feeder #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_i,
    input  logic [7:0]            data_i,
    input  logic                  dc_i,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  overflow_o,
    output logic                  idle_o,
    output logic [7:0]            spi_data_o,
    output logic                  spi_start_o,
    input  logic                  spi_busy_i,
    output logic                  dc_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [8:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            sdata_q, sdata_d;
    logic                  dc_q, dc_d;
    logic                  push, pop;
    logic [8:0]            head;

    assign full_o      = (level_q == FULL_LEVEL);
    assign empty_o     = (level_q == '0);
    assign level_o     = level_q;
    assign overflow_o  = ovf_q;
    assign spi_data_o  = sdata_q;
    assign dc_o        = dc_q;
    assign spi_start_o = (state_q == S_START);
    assign idle_o      = empty_o & (state_q == S_IDLE) & ~spi_busy_i;
    assign head        = mem_q[rptr_q];

    // full_o is taken before this cycle's pop, so a write on a full FIFO is
    // dropped even when a pop happens in the same cycle.
    assign push = wr_i & ~full_o & ~flush_i;
    assign pop  = (state_q == S_IDLE) & ~empty_o & ~spi_busy_i & ~flush_i;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        ovf_d   = ovf_q;
        sdata_d = sdata_q;
        dc_d    = dc_q;

        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (wr_i && full_o) begin
                ovf_d = 1'b1;
            end
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end

        // Flush does not abort a transfer already in START or WAIT.
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    sdata_d = head[7:0];
                    dc_d    = head[8];
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (!spi_busy_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            sdata_q <= '0;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            sdata_q <= sdata_d;
            dc_q    <= dc_d;
        end
    end

    // Storage needs no reset: level/pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= {dc_i, data_i};
        end
    end

endmodule

// File: tb/tb_spi_wo_feeder.sv
module tb_spi_wo_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] data = 8'h00;
    logic       dc = 1'b0;
    logic       flush = 1'b0;
    logic       hold = 1'b0;
    logic       full, empty, ovf, idle, start, busy, dco;
    logic [4:0] level;
    logic [7:0] sdata;

    int unsigned xfer_len = 3;
    int unsigned spi_cnt = 0;

    int errors = 0;
    int checks = 0;

    spi_wo_feeder #(.DEPTH_LOG2(4)) dut (
        .clk_i(clk), .rst_i(rst), .wr_i(wr), .data_i(data), .dc_i(dc),
        .flush_i(flush), .full_o(full), .empty_o(empty), .level_o(level),
        .overflow_o(ovf), .idle_o(idle), .spi_data_o(sdata),
        .spi_start_o(start), .spi_busy_i(busy), .dc_o(dco)
    );

    always #5 clk = ~clk;

    // SPI master stand-in: busy during the start pulse and xfer_len cycles
    // after it; it has no reset, like the real master. hold forces busy.
    assign busy = start | (spi_cnt != 0) | hold;
    always @(posedge clk) begin
        if (start) spi_cnt <= xfer_len;
        else if (spi_cnt != 0) spi_cnt <= spi_cnt - 1;
    end

    // Behavioural model: queue of entries, sticky overflow, the last issued
    // entry, and whether a transfer is starting or still in flight.
    logic [8:0] m_q[$];
    logic [8:0] m_log[$];
    logic [8:0] d_log[$];
    logic [8:0] m_e;
    logic [7:0] m_data = 8'h00;
    logic       m_dc = 1'b0;
    bit         m_ovf = 0, m_in_start = 0, m_in_flight = 0;
    bit         m_was_full, m_pop, m_busy_at_edge = 0;
    logic       prev_dc = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_ovf = 0; m_data = 8'h00; m_dc = 1'b0;
            m_in_start = 0; m_in_flight = 0; m_busy_at_edge = 0;
        end else begin
            m_busy_at_edge = busy;
            m_was_full = (m_q.size() == DEPTH);
            m_pop = !m_in_start && !m_in_flight && (m_q.size() != 0) && !busy && !flush;
            if (flush) begin
                m_q.delete();
                m_ovf = 0;
            end else begin
                if (m_pop) begin
                    m_e = m_q.pop_front();
                    m_data = m_e[7:0];
                    m_dc = m_e[8];
                    m_log.push_back(m_e);
                end
                if (wr) begin
                    if (m_was_full) m_ovf = 1;
                    else m_q.push_back({dc, data});
                end
            end
            if (m_in_start) begin
                m_in_start = 0;
                m_in_flight = 1;
            end else if (m_in_flight) begin
                if (!busy) m_in_flight = 0;
            end else if (m_pop) begin
                m_in_start = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("level", 32'(level), 32'(m_q.size()));
        chk("full", 32'(full), 32'(m_q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("overflow", 32'(ovf), 32'(m_ovf));
        chk("spi_start", 32'(start), 32'(m_in_start));
        chk("spi_data", 32'(sdata), 32'(m_data));
        chk("dc", 32'(dco), 32'(m_dc));
        chk("idle", 32'(idle),
            32'((m_q.size() == 0) && !m_in_start && !m_in_flight && !busy));
        if (!rst && dco !== prev_dc) chk("dc_change_while_busy", 32'(m_busy_at_edge), 32'd0);
        prev_dc = dco;
        if (!rst && start === 1'b1) d_log.push_back({dco, sdata});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] d, input logic c);
        wr = 1'b1; data = d; dc = c;
        step();
        wr = 1'b0;
    endtask

    task automatic wait_start(input int budget, input string name);
        int n = 0;
        while (start !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(start), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (idle !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(idle), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int base;
        int n;

        // Reset values
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_dc", 32'(dco), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        rst = 1'b0;
        step();

        // Single byte: start in cycle 2, idle one cycle after busy falls
        xfer_len = 40;
        push(8'hA5, 1'b1);
        chk("lat_c1_empty", 32'(empty), 32'd0);
        chk("lat_c1_start", 32'(start), 32'd0);
        step();
        chk("lat_c2_start", 32'(start), 32'd1);
        chk("lat_c2_data", 32'(sdata), 32'hA5);
        chk("lat_c2_dc", 32'(dco), 32'd1);
        n = 0;
        step();
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk("busy_fall_idle", 32'(idle), 32'd0);
        step();
        chk("idle_after_busy", 32'(idle), 32'd1);

        // Fill and overflow
        xfer_len = 2;
        hold = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(8'(i), 1'b1);
            if (i == 15) begin
                chk("fill_full", 32'(full), 32'd1);
                chk("fill_level16", 32'(level), 32'd16);
                chk("fill_no_ovf", 32'(ovf), 32'd0);
            end
        end
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_level16", 32'(level), 32'd16);
        base = d_log.size();
        hold = 1'b0;
        step();
        wait_idle(300, "drain_idle");
        chk("drain_count", 32'(d_log.size() - base), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < d_log.size()) chk("drain_order", 32'(d_log[base + i][7:0]), 32'(i));
        end

        // D/C switching
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_clears_ovf", 32'(ovf), 32'd0);
        hold = 1'b1;
        push(8'hAE, 1'b0);
        push(8'h55, 1'b1);
        hold = 1'b0;
        wait_start(10, "cmd_start");
        chk("cmd_data", 32'(sdata), 32'hAE);
        chk("cmd_dc", 32'(dco), 32'd0);
        step();
        wait_start(20, "data_start");
        chk("data_data", 32'(sdata), 32'h55);
        chk("data_dc", 32'(dco), 32'd1);
        wait_idle(30, "dc_idle");

        // Simultaneous push/pop at level 3, then random mix
        hold = 1'b1;
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        push(8'h33, 1'b0);
        wr = 1'b1; data = 8'h77; dc = 1'b1;
        hold = 1'b0;
        step();
        wr = 1'b0;
        chk("pushpop_level3", 32'(level), 32'd3);
        chk("pushpop_start_next", 32'(empty), 32'd0);
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            data = 8'($urandom);
            dc = 1'($urandom_range(0, 1));
            xfer_len = $urandom_range(0, 3);
            step();
        end
        wr = 1'b0;
        wait_idle(400, "random_idle");

        // Flush during WAIT
        xfer_len = 5;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1'b1);
        hold = 1'b0;
        wait_start(10, "flush_first_start");
        chk("flush_first_data", 32'(sdata), 32'hC0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_ovf", 32'(ovf), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (start === 1'b1) n++;
            step();
        end
        chk("flush_no_more_starts", 32'(n), 32'd0);
        chk("flush_inflight_done", 32'(idle), 32'd1);

        // Async reset in WAIT while the master is still busy
        xfer_len = 30;
        push(8'h3C, 1'b1);
        wait_start(10, "rst_test_start");
        step();
        step();
        #1 rst = 1'b1;
        #1;
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ovf", 32'(ovf), 32'd0);
        chk("arst_sdata", 32'(sdata), 32'd0);
        chk("arst_start", 32'(start), 32'd0);
        chk("arst_dc", 32'(dco), 32'd0);
        chk("arst_idle_busy", 32'(idle), 32'd0);
        step();
        rst = 1'b0;
        push(8'h81, 1'b0);
        n = 0;
        while (busy && n < 60) begin
            chk("no_start_while_busy", 32'(start), 32'd0);
            step();
            n++;
        end
        chk("busy_released", 32'(busy), 32'd0);
        wait_start(10, "post_reset_start");
        chk("post_reset_data", 32'(sdata), 32'h81);
        chk("post_reset_dc", 32'(dco), 32'd0);
        wait_idle(60, "final_idle");

        // Issue order over the whole run
        chk("log_size", 32'(d_log.size()), 32'(m_log.size()));
        for (int i = 0; i < m_log.size(); i++) begin
            if (i < d_log.size()) chk("log_entry", 32'(d_log[i]), 32'(m_log[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
